// File: rtl/vote_pkg.sv
// ---------------------------------------------------------------------------
// vote_pkg
// Shared definitions for the vote tally block: FSM state encoding, default
// sizing constants and a width helper for candidate / counter indices.
// No ports (package).
// ---------------------------------------------------------------------------
package vote_pkg;

    localparam int NUM_CAND   = 4;
    localparam int CNT_W      = 8;
    localparam int ACK_CYCLES = 4;

    typedef enum logic [1:0] {
        LOCKED = 2'd0,
        ARMED  = 2'd1,
        ACK    = 2'd2
    } state_e;

    // Bits needed to hold an index in 0..n-1, never less than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vote_tally_if.sv
// ---------------------------------------------------------------------------
// vote_tally_if
// Groups the voting-machine control inputs and tally outputs.
//   mode          : 0 = voting, 1 = result display
//   ballot_enable : officer pulse arming one vote
//   valid_vote    : one bit per candidate, debounced one-cycle pulses
//   result_sel    : candidate index shown in result mode
//   armed         : ballot open
//   vote_ack      : accepted-vote indication
//   multi_err     : multi-bit vote rejected (one-cycle pulse)
//   result_count  : selected candidate total (0 in voting mode)
//   sat_flag      : sticky counter-saturation flag
// Modports: master drives the inputs, slave is the tally block.
// ---------------------------------------------------------------------------
interface vote_tally_if
    import vote_pkg::*;
#(
    parameter int NUM_CAND = vote_pkg::NUM_CAND,
    parameter int CNT_W    = vote_pkg::CNT_W
);
    localparam int SEL_W = idx_w(NUM_CAND);

    logic                mode;
    logic                ballot_enable;
    logic [NUM_CAND-1:0] valid_vote;
    logic [SEL_W-1:0]    result_sel;
    logic                armed;
    logic                vote_ack;
    logic                multi_err;
    logic [CNT_W-1:0]    result_count;
    logic                sat_flag;

    modport master (
        output mode, ballot_enable, valid_vote, result_sel,
        input  armed, vote_ack, multi_err, result_count, sat_flag
    );

    modport slave (
        input  mode, ballot_enable, valid_vote, result_sel,
        output armed, vote_ack, multi_err, result_count, sat_flag
    );

endinterface

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Unsigned CNT_W-bit counter that holds at its maximum instead of wrapping.
//   clock  : system clock
//   clear  : synchronous clear to zero (dominates inc)
//   inc    : increment request
//   value  : current count
//   at_max : count equals 2^CNT_W-1
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] value,
    output logic             at_max
);

    logic [CNT_W-1:0] value_q;

    assign value  = value_q;
    assign at_max = (value_q == {CNT_W{1'b1}});

    always_ff @(posedge clock) begin
        if (clear) begin
            value_q <= '0;
        end else if (inc && !at_max) begin
            value_q <= value_q + 1'b1;
        end
    end

endmodule

// File: rtl/vote_tally.sv
// ---------------------------------------------------------------------------
// vote_tally
// Accepts one vote per officer-issued ballot, keeps a saturating count per
// candidate and shows the selected candidate's total in result mode.
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : vote_tally_if.slave (mode, ballot_enable, valid_vote,
//           result_sel in; armed, vote_ack, multi_err, result_count,
//           sat_flag out)
// ---------------------------------------------------------------------------
module vote_tally
    import vote_pkg::*;
#(
    parameter int NUM_CAND   = vote_pkg::NUM_CAND,
    parameter int CNT_W      = vote_pkg::CNT_W,
    parameter int ACK_CYCLES = vote_pkg::ACK_CYCLES
) (
    input  logic         clock,
    input  logic         reset,
    vote_tally_if.slave  bus
);

    localparam int ACK_W = idx_w(ACK_CYCLES);

    state_e              state_q;
    logic                armed_q;
    logic                ack_q;
    logic [ACK_W-1:0]    ack_cnt_q;
    logic                merr_q;
    logic [CNT_W-1:0]    res_q;
    logic [CNT_W-1:0]    res_d;
    logic                sat_q;

    logic                vote_one;
    logic                vote_multi;
    logic                accept;
    logic [NUM_CAND-1:0] inc;
    logic [NUM_CAND-1:0] at_max;
    logic [NUM_CAND-1:0] sat_hit;
    logic [CNT_W-1:0]    cnt [NUM_CAND];

    assign vote_one   = ($countones(bus.valid_vote) == 1);
    assign vote_multi = ($countones(bus.valid_vote) > 1);

    // A vote counts only while armed and still in voting mode; mode=1 in the
    // same cycle discards the ballot.
    assign accept  = (state_q == ARMED) && !bus.mode && vote_one;
    assign inc     = accept ? bus.valid_vote : '0;
    assign sat_hit = inc & at_max;

    for (genvar i = 0; i < NUM_CAND; i++) begin : g_cnt
        sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clock  (clock),
            .clear  (reset),
            .inc    (inc[i]),
            .value  (cnt[i]),
            .at_max (at_max[i])
        );
    end

    // Compare rather than index so an out-of-range select reads as zero.
    always_comb begin
        res_d = '0;
        if (bus.mode) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                if (int'(bus.result_sel) == i) begin
                    res_d = cnt[i];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= LOCKED;
            armed_q   <= 1'b0;
            ack_q     <= 1'b0;
            ack_cnt_q <= '0;
            merr_q    <= 1'b0;
            res_q     <= '0;
            sat_q     <= 1'b0;
        end else begin
            merr_q <= 1'b0;
            res_q  <= res_d;
            if (|sat_hit) begin
                sat_q <= 1'b1;
            end

            case (state_q)
                LOCKED: begin
                    if (bus.ballot_enable && !bus.mode) begin
                        state_q <= ARMED;
                        armed_q <= 1'b1;
                    end
                end
                ARMED: begin
                    if (bus.mode) begin
                        state_q <= LOCKED;
                        armed_q <= 1'b0;
                    end else if (vote_one) begin
                        state_q   <= ACK;
                        armed_q   <= 1'b0;
                        ack_q     <= 1'b1;
                        ack_cnt_q <= ACK_W'(ACK_CYCLES - 1);
                    end else if (vote_multi) begin
                        merr_q <= 1'b1;
                    end
                end
                ACK: begin
                    // Counts down the remaining ack cycles; inputs ignored.
                    if (ack_cnt_q == '0) begin
                        state_q <= LOCKED;
                        ack_q   <= 1'b0;
                    end else begin
                        ack_cnt_q <= ack_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= LOCKED;
                    armed_q <= 1'b0;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.armed        = armed_q;
    assign bus.vote_ack     = ack_q;
    assign bus.multi_err    = merr_q;
    assign bus.result_count = res_q;
    assign bus.sat_flag     = sat_q;

endmodule

// File: doc/vote_tally.md
Name: vote_tally

Overview:
- Downstream consumer of the per-candidate debounced `valid_vote` pulses.
- Enforces one vote per officer-issued ballot and keeps a saturating per-candidate count.
- In result mode, presents the selected candidate's total to the display stage.
- Sits between the per-button debounce stages and the display/result logic of the voting machine.

Parameters:
- NUM_CAND, 4: number of candidates; one valid_vote bit each.
- CNT_W, 8: width of each candidate counter.
- ACK_CYCLES, 4: duration of the vote_ack indication, in clocks (>=1).

Ports:
- clock  in  1  single system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- mode  in  1  0 = voting, 1 = result display.
- ballot_enable  in  1  officer pulse that arms the machine for one vote.
- valid_vote  in  NUM_CAND  one-cycle vote pulses from the debounce stages; bit i = candidate i.
- result_sel  in  $clog2(NUM_CAND)  candidate index to display.
- armed  out  1  high while a ballot is open.
- vote_ack  out  1  high for ACK_CYCLES after an accepted vote.
- multi_err  out  1  one-cycle pulse when a multi-bit vote is rejected.
- result_count  out  CNT_W  selected candidate's count; 0 when mode=0.
- sat_flag  out  1  sticky; set when any counter is held at its maximum value.

Behaviour:
- Reset values: state=LOCKED, all counters=0, armed=0, vote_ack=0, multi_err=0, result_count=0, sat_flag=0. Reset wins over every other input in the same cycle.
- The debounce stage drives valid_vote high during reset and for the first cycle after reset. This is harmless because LOCKED ignores valid_vote.
- FSM states are LOCKED, ARMED and ACK.
- LOCKED:
  - ballot_enable=1 and mode=0 -> ARMED.
  - valid_vote is ignored.
- ARMED (armed=1):
  - mode=1 -> LOCKED; the ballot is discarded and no count changes.
  - Exactly one valid_vote bit set at edge t -> that counter increments at t. The new value is visible from cycle t+1. Next state is ACK.
  - More than one bit set -> no counter changes, multi_err=1 for the cycle t+1, state stays ARMED.
  - ballot_enable while ARMED has no effect; ballots do not stack.
  - mode=1 together with a vote in the same cycle -> mode wins; no count.
- ACK:
  - vote_ack=1 for exactly ACK_CYCLES cycles (t+1 .. t+ACK_CYCLES), then the state returns to LOCKED.
  - valid_vote and ballot_enable are ignored during ACK.
  - mode is ignored during ACK; the ACK period always completes.
- Counters:
  - Unsigned, CNT_W bits, saturating.
  - An increment at 2^CNT_W-1 holds the value and sets sat_flag. sat_flag clears only on reset.
  - No wrap-around.
- result_count:
  - Registered, 1-cycle latency from result_sel/mode.
  - Equals count[result_sel] when mode=1, else 0.
  - An out-of-range result_sel (when NUM_CAND is not a power of two) yields 0.
- Reset mid-ACK or mid-ARMED -> LOCKED next cycle with all counts cleared.

Decomposition:
- Shared package vote_pkg holds:
  - The state enum (LOCKED, ARMED, ACK).
  - Default constants NUM_CAND, CNT_W, ACK_CYCLES.
  - Width helper for the candidate index.
- One sub-module, sat_counter: CNT_W-bit counter with inputs inc and clear, outputs value and at_max. It is instantiated NUM_CAND times.
- The FSM, the one-hot check (popcount == 1) and the result mux stay in vote_tally.

Test Plan:
1. Reset asserted 3 cycles with valid_vote=4'b1111, then released with valid_vote=4'b1111 for one more cycle -> all counts 0, armed=0, no vote_ack.
2. mode=0, ballot_enable pulse, then valid_vote=4'b0100 one cycle -> count[2]=1 next cycle, vote_ack high exactly 4 cycles, then armed=0. A second valid_vote=4'b0100 without a new ballot -> count[2] stays 1.
3. Armed, then valid_vote=4'b0011 -> multi_err pulses 1 cycle, counts unchanged, armed stays 1. A following 4'b0001 -> count[0]=1.
4. CNT_W=3: 8 ballot+vote pairs to candidate 1 -> count[1] holds 7, sat_flag=1 after the 8th vote and stays 1 until reset.
5. Armed, then mode=1 and valid_vote=4'b1000 in the same cycle -> no count, state LOCKED. With result_sel=1, result_count shows count[1] one cycle later; mode=0 -> result_count=0 one cycle later.
6. Reset asserted during the 2nd ACK cycle -> vote_ack=0, all counts 0 the next cycle.
